// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises core fetch and load/store onto one memory bus.
// Data access goes first; a one-entry fetch buffer avoids re-reading the same word.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [31:0] I_imem_addr,
   output logic [31:0] O_imem_data,
   input  logic [31:0] I_dmem_addr,
   input  logic [31:0] I_dmem_wdata,
   input  logic [3:0]  I_dmem_wmask,
   input  logic        I_dmem_rd,
   input  logic        I_dmem_we,
   output logic [31:0] O_dmem_rdata,
   output logic        O_stall,
   output logic        O_mem_req,
   output logic        O_mem_we,
   output logic [31:0] O_mem_addr,
   output logic [31:0] O_mem_wdata,
   output logic [3:0]  O_mem_wmask,
   input  logic        I_mem_ack,
   input  logic [31:0] I_mem_rdata,
   output logic        O_bus_err
);

   typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

   localparam logic [7:0] TO = TIMEOUT[7:0];

   state_t      state;
   state_t      state_n;
   logic [29:0] ibuf_addr;
   logic        ibuf_valid;
   logic        done_d;
   logic [7:0]  wd_cnt;

   logic        i_hit;
   logic        need_i;
   logic        need_d;
   logic        wd_hit;
   logic        issue_d;
   logic        issue_i;
   logic        fin;
   logic        abort;
   logic [31:0] fin_rdata;
   logic        unused_lo;

   assign unused_lo = ^I_imem_addr[1:0];

   assign i_hit   = ibuf_valid && (ibuf_addr == I_imem_addr[31:2]);
   assign need_i  = !i_hit;
   assign need_d  = I_dmem_rd | I_dmem_we;
   assign O_stall = I_rst | need_i | (need_d & !done_d);

   assign wd_hit    = (TO != 8'd0) && (wd_cnt == TO);
   assign fin_rdata = abort ? 32'h0 : I_mem_rdata;

   always_comb begin
      state_n = state;
      issue_d = 1'b0;
      issue_i = 1'b0;
      fin     = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (need_d && !done_d) begin
               state_n = D_WAIT;
               issue_d = 1'b1;
            end else if (need_i) begin
               state_n = I_WAIT;
               issue_i = 1'b1;
            end
         end
         D_WAIT, I_WAIT: begin
            // a real ack wins over a simultaneous watchdog expiry
            if (I_mem_ack) begin
               fin     = 1'b1;
               state_n = IDLE;
            end else if (wd_hit) begin
               fin     = 1'b1;
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state        <= IDLE;
         ibuf_addr    <= 30'h0;
         ibuf_valid   <= 1'b0;
         O_imem_data  <= 32'h0;
         O_dmem_rdata <= 32'h0;
         done_d       <= 1'b0;
         wd_cnt       <= 8'h0;
         O_mem_req    <= 1'b0;
         O_mem_we     <= 1'b0;
         O_mem_addr   <= 32'h0;
         O_mem_wdata  <= 32'h0;
         O_mem_wmask  <= 4'h0;
         O_bus_err    <= 1'b0;
      end else begin
         state     <= state_n;
         O_bus_err <= abort;

         if (issue_d) begin
            O_mem_req   <= 1'b1;
            O_mem_we    <= I_dmem_we;
            O_mem_addr  <= I_dmem_addr;
            O_mem_wdata <= I_dmem_wdata;
            O_mem_wmask <= I_dmem_we ? I_dmem_wmask : 4'h0;
            wd_cnt      <= 8'h0;
         end else if (issue_i) begin
            O_mem_req   <= 1'b1;
            O_mem_we    <= 1'b0;
            O_mem_addr  <= {I_imem_addr[31:2], 2'b00};
            O_mem_wmask <= 4'h0;
            wd_cnt      <= 8'h0;
         end else if (fin) begin
            O_mem_req <= 1'b0;
         end else if (state != IDLE) begin
            wd_cnt <= wd_cnt + 8'd1;
         end

         if (fin && state == D_WAIT) begin
            if (!O_mem_we) begin
               O_dmem_rdata <= fin_rdata;
            end else if (ibuf_addr == O_mem_addr[31:2]) begin
               ibuf_valid <= 1'b0;
            end
         end

         // buffer tag is the issued address, not the current core address
         if (fin && state == I_WAIT) begin
            ibuf_addr   <= O_mem_addr[31:2];
            O_imem_data <= fin_rdata;
            ibuf_valid  <= 1'b1;
         end

         if (fin && state == D_WAIT) begin
            done_d <= 1'b1;
         end else if (!O_stall || !need_d) begin
            done_d <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory sequencer between the pipelined core's instruction-fetch and data ports and one shared external memory bus. Serialises each core cycle's fetch and load/store into bus transactions (data first), holds the core with a stall until every access that cycle needs has completed, and keeps a one-entry fetch buffer so a stalled or repeated fetch address is not re-read. Includes a per-transaction ack watchdog.

## Interface
- TIMEOUT, 255: max cycles waiting for I_mem_ack before abort; 0 disables the watchdog (8-bit counter).
- I_clk  in  1  clock; all state on rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_imem_addr  in  32  core fetch address; a fetch is needed every cycle.
- O_imem_data  out  32  fetched instruction (registered fetch-buffer data).
- I_dmem_addr  in  32  core data address.
- I_dmem_wdata  in  32  store data.
- I_dmem_wmask  in  4  store byte enables.
- I_dmem_rd  in  1  load request this core cycle.
- I_dmem_we  in  1  store request this core cycle (rd and we are never both high).
- O_dmem_rdata  out  32  load data, registered, held until the next load completes.
- O_stall  out  1  combinational; holds the core pipeline.
- O_mem_req  out  1  bus request, registered.
- O_mem_we  out  1  bus write.
- O_mem_addr  out  32  bus address.
- O_mem_wdata  out  32  bus write data.
- O_mem_wmask  out  4  bus byte enables; 4'b0000 on reads.
- I_mem_ack  in  1  bus completion; sampled only while O_mem_req=1.
- I_mem_rdata  in  32  bus read data, valid with I_mem_ack.
- O_bus_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- Fetch buffer: ibuf_addr[31:2], ibuf_data, ibuf_valid. i_hit = ibuf_valid && ibuf_addr == I_imem_addr[31:2]. need_i = !i_hit.
- need_d = I_dmem_rd | I_dmem_we; done_d flag set on data completion.
- O_stall = I_rst | need_i | (need_d & !done_d).
- done_d clears on any edge where O_stall=0 (core advances) or need_d=0.
- FSM states IDLE, D_WAIT, I_WAIT.
- IDLE: if need_d & !done_d -> D_WAIT, drive req=1, we=I_dmem_we, addr=I_dmem_addr, wdata=I_dmem_wdata, wmask=we ? I_dmem_wmask : 0. Else if need_i -> I_WAIT, req=1, we=0, addr={I_imem_addr[31:2],2'b00}, wmask=0. Else stay.
- Data has priority over fetch whenever both are pending in IDLE.
- D_WAIT/I_WAIT: bus fields held stable while req=1. On I_mem_ack: req=0, -> IDLE. D_WAIT ack: done_d=1; load -> O_dmem_rdata<=I_mem_rdata; store whose addr[31:2]==ibuf_addr -> ibuf_valid=0. I_WAIT ack: ibuf_addr<=bus addr[31:2], ibuf_data<=I_mem_rdata, ibuf_valid=1.
- Fetch buffer is filled with the address latched at issue; if I_imem_addr changed meanwhile, the next IDLE sees a miss and refetches.
- Watchdog: counter clears on entering a WAIT state, increments each WAIT cycle without ack; when it equals TIMEOUT (TIMEOUT≠0): abort as if acked with rdata=32'h0 (fetch yields NOP 0), O_bus_err=1 next cycle for one cycle.
- Reset: state IDLE, ibuf_valid=0, done_d=0, counter 0; any ack arriving after reset is ignored (req=0).

## Timing
- Reset values: O_mem_req 0, O_mem_we 0, O_mem_addr 0, O_mem_wdata 0, O_mem_wmask 0, O_imem_data 0, O_dmem_rdata 0, O_bus_err 0; O_stall 1 during reset.
- req rises the cycle after IDLE decision; ack may arrive the first cycle req is high (zero-wait).
- req is always low for at least one cycle between transactions.
- Zero-wait fetch miss: addr new at cycle N, req N+1, ack N+1, hit and O_stall=0 at N+2 (2-cycle penalty).
- Zero-wait load+fetch miss: D req N+1/ack N+1, IDLE N+2, I req/ack N+3, O_stall=0 at N+4; O_dmem_rdata valid from N+2.
- Fetch hit with no data access: O_stall=0 combinationally, no bus activity.
- Bus wait states extend each transaction 1:1.

## Test plan
- Reset then I_imem_addr=0, mem returns 32'h2408_0005 zero-wait -> req at cycle 1, O_imem_data=32'h24080005 and O_stall=0 at cycle 2; holding addr 0 gives no further req.
- Load I_dmem_addr=0x100 (mem 0xDEADBEEF) with fetch miss 0x4 -> data transaction first, then fetch; O_dmem_rdata=0xDEADBEEF, O_stall low exactly one cycle after fetch ack.
- Store to 0x4 (wmask 4'b0011, wdata 0x1234) while ibuf holds 0x4 -> O_mem_we=1, O_mem_wmask=4'b0011; ibuf invalidated, next cycle refetches 0x4.
- ack delayed 3 cycles -> bus addr/wdata/wmask stable all 4 req cycles, O_stall high throughout.
- TIMEOUT=4, no ack -> abort after 4 wait cycles, O_bus_err one-cycle pulse, O_imem_data=0, core released.
- I_rst asserted in D_WAIT with ack next cycle -> req 0, ack ignored, ibuf invalid, O_dmem_rdata 0.
